rle_span_decoder: RTL and testbench



---
 rtl/rle_vga_pkg.sv | 11 +
 rtl/rle_token_fifo.sv | 42 ++++
 rtl/rle_span_decoder.sv | 89 ++++++++
 tb/tb_rle_span_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rle_vga_pkg.sv
// rle_vga_pkg: shared widths, token layout and decoder states for the RLE video path
package rle_vga_pkg;
    localparam int DEF_COLOUR_W = 6;
    localparam int DEF_RUN_W = 10;
    localparam logic [DEF_RUN_W-1:0] RUN_EOL = '1;
    typedef struct packed {
        logic [DEF_RUN_W-1:0] run;
        logic [DEF_COLOUR_W-1:0] colour;
    } token_t;
    typedef enum logic [1:0] {IDLE, RUN, EOL} dec_state_t;
endpackage

// File: rtl/rle_token_fifo.sv
// rle_token_fifo: small token FIFO with wrap-bit pointers and a synchronous flush
module rle_token_fifo #(
    parameter int W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign level = wr - rd;
    assign empty = wr == rd;
    assign full = (wr ^ rd) == {1'b1, {AW{1'b0}}};
    assign dout = mem[rd[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else if (flush) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rle_span_decoder.sv
// rle_span_decoder: expands buffered {run, colour} tokens into one registered colour per active pixel
import rle_vga_pkg::*;
module rle_span_decoder #(
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int RUN_W = DEF_RUN_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tok_valid,
    output logic                          tok_ready,
    input  logic [RUN_W+COLOUR_W-1:0]     tok_data,
    input  logic                          frame_start,
    input  logic                          line_start,
    input  logic                          pix_en,
    output logic [COLOUR_W-1:0]           colour_out,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam logic [RUN_W-1:0] RUN_ALL = '1;
    logic [RUN_W+COLOUR_W-1:0] head;
    logic [RUN_W-1:0] head_run, rem, rem_n;
    logic [COLOUR_W-1:0] head_col, cur, cur_n, colour_n;
    logic full, empty, push, pop, underflow_n;
    dec_state_t state, state_n, base;
    assign tok_ready = !rst && !full && !frame_start;
    assign push = tok_valid && tok_ready;
    assign {head_run, head_col} = head;
    rle_token_fifo #(.W(RUN_W + COLOUR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(frame_start),
        .push(push),
        .pop(pop),
        .din(tok_data),
        .dout(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
    // line_start releases an end-of-line hold before this cycle's pixel is evaluated
    always_comb begin
        base = (line_start && state == EOL) ? IDLE : state;
        state_n = base;
        rem_n = rem;
        cur_n = cur;
        colour_n = '0;
        underflow_n = underflow;
        pop = 1'b0;
        if (frame_start) begin
            state_n = IDLE;
            rem_n = '0;
            underflow_n = 1'b0;
        end else if (pix_en) begin
            if (base == IDLE) begin
                if (empty) begin
                    underflow_n = 1'b1;
                end else begin
                    pop = 1'b1;
                    colour_n = head_col;
                    cur_n = head_col;
                    rem_n = head_run;
                    state_n = (head_run == RUN_ALL) ? EOL : (head_run != '0) ? RUN : IDLE;
                end
            end else begin
                colour_n = cur;
                if (base == RUN) begin
                    rem_n = rem - 1'b1;
                    state_n = (rem == RUN_W'(1)) ? IDLE : RUN;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem <= '0;
            cur <= '0;
            colour_out <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_n;
            rem <= rem_n;
            cur <= cur_n;
            colour_out <= colour_n;
            underflow <= underflow_n;
        end
    end
endmodule

// File: tb/tb_rle_span_decoder.sv
// tb_rle_span_decoder: directed scoreboard bench for the default and a swept decoder configuration
import rle_vga_pkg::*;
module tb_rle_span_decoder;
    logic clk = 0;
    logic rst = 0;
    logic tok_valid = 0, frame_start = 0, line_start = 0, pix_en = 0;
    logic [15:0] tok_data = '0;
    logic tok_ready, underflow;
    logic [5:0] colour_out;
    logic [2:0] fifo_level;
    logic b_valid = 0, b_frame = 0, b_line = 0, b_pix = 0;
    logic [11:0] b_data = '0;
    logic b_ready, b_underflow;
    logic [7:0] b_colour;
    logic [3:0] b_level;
    int total = 0, passed = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b[$];
    token_t tk;

    always #5 clk = ~clk;

    rle_span_decoder dut (
        .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_data(tok_data),
        .frame_start(frame_start), .line_start(line_start), .pix_en(pix_en),
        .colour_out(colour_out), .underflow(underflow), .fifo_level(fifo_level)
    );

    rle_span_decoder #(.COLOUR_W(8), .RUN_W(4), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .tok_valid(b_valid), .tok_ready(b_ready), .tok_data(b_data),
        .frame_start(b_frame), .line_start(b_line), .pix_en(b_pix),
        .colour_out(b_colour), .underflow(b_underflow), .fifo_level(b_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] run, input logic [5:0] col);
        tk.run = run;
        tk.colour = col;
        tok_data = tk;
        tok_valid = 1;
        tick();
        tok_valid = 0;
    endtask

    task automatic pix(input logic [7:0] e);
        pix_en = 1;
        exp_q.push_back(e);
        tick();
        chk("colour", 32'(colour_out), 32'(exp_q.pop_front()));
    endtask

    task automatic pix_b(input logic [7:0] e);
        b_pix = 1;
        exp_b.push_back(e);
        tick();
        chk("colour_b", 32'(b_colour), 32'(exp_b.pop_front()));
    endtask

    task automatic flush();
        pix_en = 0;
        frame_start = 1;
        tick();
        frame_start = 0;
    endtask

    initial begin
        #2 rst = 1;
        #1;
        chk("rst_ready", 32'(tok_ready), 0);
        chk("rst_colour", 32'(colour_out), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_underflow", 32'(underflow), 0);
        tick();
        rst = 0;
        tick();
        chk("ready_after_rst", 32'(tok_ready), 1);

        // basic runs: 3 pixels of 3F, 1 of 05, then underflow
        push(10'd2, 6'h3F);
        push(10'd0, 6'h05);
        chk("basic_level", 32'(fifo_level), 2);
        pix(8'h3F); pix(8'h3F); pix(8'h3F); pix(8'h05); pix(8'h00);
        chk("basic_underflow", 32'(underflow), 1);
        pix_en = 0;
        tick();
        chk("blank", 32'(colour_out), 0);

        // frame flush with a simultaneous push and pixel
        push(10'd0, 6'h11);
        push(10'd0, 6'h22);
        chk("flush_level_pre", 32'(fifo_level), 2);
        frame_start = 1; pix_en = 1; tok_valid = 1; tok_data = 16'h0033;
        #1 chk("flush_ready_low", 32'(tok_ready), 0);
        tick();
        frame_start = 0; pix_en = 0; tok_valid = 0;
        chk("flush_level", 32'(fifo_level), 0);
        chk("flush_underflow", 32'(underflow), 0);
        chk("flush_colour", 32'(colour_out), 0);
        pix(8'h00);
        chk("flush_push_dropped", 32'(underflow), 1);
        flush();

        // backpressure: fifth token waits for a pop
        for (int i = 1; i <= 4; i++) push(10'd0, 6'(i));
        chk("bp_level_full", 32'(fifo_level), 4);
        chk("bp_ready_low", 32'(tok_ready), 0);
        tk.run = 0; tk.colour = 6'h05; tok_data = tk; tok_valid = 1;
        tick();
        chk("bp_held_level", 32'(fifo_level), 4);
        pix(8'h01);
        chk("bp_level_after_pop", 32'(fifo_level), 3);
        pix_en = 0;
        tick();
        tok_valid = 0;
        chk("bp_level_refill", 32'(fifo_level), 4);
        pix(8'h02); pix(8'h03); pix(8'h04); pix(8'h05);
        chk("bp_no_underflow", 32'(underflow), 0);
        flush();

        // EOL hold until line_start
        push(10'h3FF, 6'h12);
        push(10'd1, 6'h21);
        for (int i = 0; i < 10; i++) pix(8'h12);
        line_start = 1;
        pix(8'h21);
        line_start = 0;
        pix(8'h21);
        chk("eol_no_underflow", 32'(underflow), 0);
        pix(8'h00);
        chk("eol_underflow", 32'(underflow), 1);
        flush();

        // asynchronous reset mid-run with three tokens queued
        push(10'd5, 6'h0A);
        for (int i = 1; i <= 3; i++) push(10'd0, 6'(i));
        pix(8'h0A); pix(8'h0A);
        chk("mid_level", 32'(fifo_level), 3);
        rst = 1;
        #1;
        chk("async_colour", 32'(colour_out), 0);
        chk("async_level", 32'(fifo_level), 0);
        chk("async_ready", 32'(tok_ready), 0);
        pix_en = 0;
        tick();
        rst = 0;
        tick();
        chk("release_ready", 32'(tok_ready), 1);
        pix(8'h00);
        chk("release_empty_underflow", 32'(underflow), 1);
        pix_en = 0;

        // swept configuration: run=14 spans 15 pixels, run=15 holds to end of line
        b_data = {4'd14, 8'hAA}; b_valid = 1;
        tick();
        b_data = {4'd15, 8'hBB};
        tick();
        b_valid = 0;
        chk("b_level", 32'(b_level), 2);
        for (int i = 0; i < 15; i++) pix_b(8'hAA);
        for (int i = 0; i < 5; i++) pix_b(8'hBB);
        chk("b_no_underflow", 32'(b_underflow), 0);
        b_line = 1;
        pix_b(8'h00);
        b_line = 0;
        b_pix = 0;
        chk("b_eol_underflow", 32'(b_underflow), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
